gate_truth_table_checker: RTL

Sequential self-test engine for the single-output universal-gate micro projects (NAND-built NOT, AND, OR, XOR, …). It drives every input combination into the gate under test, samples the gate's output after a settle time, and compares it against an internal reference model for a selected function. It reports pass/fail, a mismatch count and the first failing vector. In the bench and FPGA top levels it sits between the gate under test and the LEDs/ILA.

---
 rtl/gate_chk_pkg.sv | 27 ++
 rtl/gate_ref_model.sv | 37 +++
 rtl/gate_truth_table_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
// Shared definitions for the universal-gate self-test engine:
//   - OP_* : 3-bit encoding of the expected gate function
//   - state_e : sweep FSM state type
// -----------------------------------------------------------------------------
package gate_chk_pkg;

    // Expected-function encoding driven on the checker's op input.
    localparam logic [2:0] OP_BUF  = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    // Sweep FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
// Purely combinational golden model of a single-output gate.
// Ports:
//   op       in  3     expected function (OP_BUF .. OP_XNOR)
//   x        in  N_IN  input vector applied to the gate
//   expected out 1     output the selected gate should produce for x
// BUF/NOT look at x[0] only; AND/OR/XOR reduce over all N_IN bits and
// NAND/NOR/XNOR are their inversions.
// -----------------------------------------------------------------------------
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      op,
    input  logic [N_IN-1:0] x,
    output logic            expected
);

    // Select the reference output for the requested function.
    always_comb begin
        expected = 1'b0;
        case (op)
            OP_BUF:  expected = x[0];
            OP_NOT:  expected = ~x[0];
            OP_AND:  expected = &x;
            OP_OR:   expected = |x;
            OP_NAND: expected = ~(&x);
            OP_NOR:  expected = ~(|x);
            OP_XOR:  expected = ^x;
            OP_XNOR: expected = ~(^x);
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_table_checker
// Sweeps every input combination into a gate under test, samples the gate
// output after SETTLE extra cycles per vector and compares it against
// gate_ref_model for the function latched at start.
// Parameters:
//   N_IN    number of gate inputs driven (1..8)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
// Ports:
//   clk        in   1       clock, posedge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       sweep request, honoured in IDLE only
//   op         in   3       expected function, latched with start
//   X          out  N_IN    stimulus vector to the gate under test
//   Y          in   1       gate under test output (synchronous to clk)
//   busy       out  1       high from accepted start until done
//   done       out  1       one-cycle completion pulse
//   pass       out  1       last sweep had zero mismatches
//   fail_count out  N_IN+1  mismatches in the last sweep
//   first_fail out  N_IN    vector of the first mismatch (0 if none)
// All outputs are registered.
// -----------------------------------------------------------------------------
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    output logic [N_IN-1:0] X,
    input  logic            Y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail
);

    // Last value of the settle counter before moving on to SAMPLE.
    localparam logic [3:0]      SETTLE_LAST = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);
    // With no settle time, HOLD is bypassed and every vector goes straight to SAMPLE.
    localparam state_e          ST_VEC_ENTRY = (SETTLE > 0) ? ST_HOLD : ST_SAMPLE;
    localparam logic [N_IN-1:0] X_ONE  = N_IN'(1'b1);
    localparam logic [N_IN:0]   FC_ONE = (N_IN + 1)'(1'b1);

    state_e            state_r, state_s;
    logic [2:0]        op_r, op_s;
    logic [N_IN-1:0]   x_r, x_s;
    logic [3:0]        settle_cnt_r, settle_cnt_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              pass_r, pass_s;
    logic [N_IN:0]     fail_count_r, fail_count_s;
    logic [N_IN-1:0]   first_fail_r, first_fail_s;
    logic              expected_s;
    logic              mismatch_s;

    gate_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .op       (op_r),
        .x        (x_r),
        .expected (expected_s)
    );

    assign mismatch_s = (Y != expected_s);

    // Next-state and next-register computation for the sweep FSM.
    always_comb begin
        state_s      = state_r;
        op_s         = op_r;
        x_s          = x_r;
        settle_cnt_s = settle_cnt_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        pass_s       = pass_r;
        fail_count_s = fail_count_r;
        first_fail_s = first_fail_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_s         = op;
                    x_s          = '0;
                    settle_cnt_s = 4'd0;
                    fail_count_s = '0;
                    first_fail_s = '0;
                    pass_s       = 1'b0;
                    busy_s       = 1'b1;
                    state_s      = ST_VEC_ENTRY;
                end else begin
                    state_s      = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    settle_cnt_s = 4'd0;
                    state_s      = ST_SAMPLE;
                end else begin
                    settle_cnt_s = settle_cnt_r + 4'd1;
                    state_s      = ST_HOLD;
                end
            end

            ST_SAMPLE: begin
                if (mismatch_s) begin
                    // At most 2^N_IN mismatches, so the N_IN+1 bit counter never wraps.
                    fail_count_s = fail_count_r + FC_ONE;
                    if (fail_count_r == '0) begin
                        first_fail_s = x_r;
                    end else begin
                        first_fail_s = first_fail_r;
                    end
                end else begin
                    fail_count_s = fail_count_r;
                end

                if (&x_r) begin
                    // Result flags rise together with done, so pass already
                    // includes the compare of this final vector.
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (fail_count_s == '0);
                    state_s = ST_DONE;
                end else begin
                    x_s     = x_r + X_ONE;
                    state_s = ST_VEC_ENTRY;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_BUF;
            x_r          <= '0;
            settle_cnt_r <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_count_r <= '0;
            first_fail_r <= '0;
        end else begin
            state_r      <= state_s;
            op_r         <= op_s;
            x_r          <= x_s;
            settle_cnt_r <= settle_cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            fail_count_r <= fail_count_s;
            first_fail_r <= first_fail_s;
        end
    end

    assign X          = x_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign fail_count = fail_count_r;
    assign first_fail = first_fail_r;

endmodule
